// File: rtl/axis_step_sequencer_pkg.sv
// Shared types and default constants for the step/dir axis sequencer.
package step_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_JOG
    } state_t;

    localparam int DEF_CNT_W    = 20;
    localparam int DEF_STEPS_W  = 16;
    localparam int DEF_JOG_HALF = 40000;

endpackage

// File: rtl/axis_step_sequencer_sync2.sv
// Two-flop synchroniser for asynchronous level inputs (used for endstops).
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/axis_step_sequencer.sv
// Multi-axis step/dir pulse sequencer with segment commands and manual jog.
// Optional endstop handling is enabled by defining AXIS_STEP_SEQUENCER_ENDSTOP_EN.
module axis_step_sequencer
    import step_seq_pkg::*;
#(
    parameter int N_AXES    = 3,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int STEPS_W   = DEF_STEPS_W,
    parameter int DIR_SETUP = 16,
    parameter int JOG_HALF  = DEF_JOG_HALF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               seq_mode,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [N_AXES-1:0]  cmd_en,
    input  logic [N_AXES-1:0]  cmd_dir,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic [CNT_W-1:0]   cmd_half,
    input  logic [N_AXES-1:0]  jog_en,
    input  logic [N_AXES-1:0]  jog_dir,
    output logic [N_AXES-1:0]  step,
    output logic [N_AXES-1:0]  dir,
    output logic               busy,
    output logic               done
`ifdef AXIS_STEP_SEQUENCER_ENDSTOP_EN
    ,
    input  logic [N_AXES-1:0]  endstop,
    output logic               fault
`endif
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((DIR_SETUP > 0) ? DIR_SETUP - 1 : 0);
    localparam logic [CNT_W-1:0] JOG_LAST   = CNT_W'(JOG_HALF - 1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_timer, w_timer_nxt;
    logic [STEPS_W-1:0] r_count, w_count_nxt;
    logic [STEPS_W-1:0] r_steps;
    logic [CNT_W-1:0]   r_half;
    logic [N_AXES-1:0]  r_en;
    logic [N_AXES-1:0]  r_step, w_step_nxt;
    logic [N_AXES-1:0]  r_dir, w_dir_nxt;
    logic               r_done, w_done_nxt;
    logic               r_jog_high, w_jog_high_nxt;
    logic               w_accept;
    logic               w_half_last;
    logic [STEPS_W-1:0] w_count_inc;

    assign cmd_ready   = rst_n && (r_state == S_IDLE) && seq_mode;
    assign w_half_last = (r_timer == (r_half - CNT_W'(1)));
    assign w_count_inc = r_count + STEPS_W'(1);

`ifdef AXIS_STEP_SEQUENCER_ENDSTOP_EN
    logic [N_AXES-1:0] w_endstop_sync;
    logic [N_AXES-1:0] w_axis_en;
    logic              w_es_hit;
    logic              r_fault;

    sync2 #(.WIDTH(N_AXES)) u_endstop_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (endstop),
        .q     (w_endstop_sync)
    );

    // Only axes that are moving toward the switch (dir == 0) may trip it.
    assign w_axis_en = (r_state == S_JOG) ? jog_en : r_en;
    assign w_es_hit  = |(w_endstop_sync & w_axis_en & ~r_dir);
    assign fault     = r_fault;
`endif

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer + CNT_W'(1);
        w_count_nxt    = r_count;
        w_step_nxt     = '0;
        w_dir_nxt      = r_dir;
        w_done_nxt     = 1'b0;
        w_jog_high_nxt = r_jog_high;
        w_accept       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                w_count_nxt = '0;
                if (cmd_valid && cmd_ready) begin
                    w_accept  = 1'b1;
                    w_dir_nxt = cmd_dir;
                    if (cmd_steps == '0) begin
                        w_done_nxt = 1'b1;
                    end else if (DIR_SETUP == 0) begin
                        w_state_nxt = S_HIGH;
                        w_step_nxt  = cmd_en;
                    end else begin
                        w_state_nxt = S_SETUP;
                    end
                end else if (!seq_mode && (|jog_en)) begin
                    w_state_nxt    = S_JOG;
                    w_jog_high_nxt = 1'b1;
                    w_step_nxt     = jog_en;
                    w_dir_nxt      = jog_dir;
                end
            end
            S_SETUP: begin
                if (r_timer == SETUP_LAST) begin
                    w_state_nxt = S_HIGH;
                    w_timer_nxt = '0;
                    w_step_nxt  = r_en;
                end
            end
            S_HIGH: begin
                if (w_half_last) begin
                    w_state_nxt = S_LOW;
                    w_timer_nxt = '0;
                end else begin
                    w_step_nxt = r_en;
                end
            end
            S_LOW: begin
                if (w_half_last) begin
                    w_timer_nxt = '0;
                    if (w_count_inc == r_steps) begin
                        w_state_nxt = S_IDLE;
                        w_count_nxt = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_HIGH;
                        w_count_nxt = w_count_inc;
                        w_step_nxt  = r_en;
                    end
                end
            end
            S_JOG: begin
                if (seq_mode || !(|jog_en)) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                    w_dir_nxt   = '0;
                end else begin
                    w_dir_nxt = jog_dir;
                    if (r_timer == JOG_LAST) begin
                        w_timer_nxt    = '0;
                        w_jog_high_nxt = !r_jog_high;
                    end
                    w_step_nxt = jog_en & {N_AXES{w_jog_high_nxt}};
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
                w_count_nxt = '0;
            end
        endcase

`ifdef AXIS_STEP_SEQUENCER_ENDSTOP_EN
        if ((r_state != S_IDLE) && w_es_hit) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
            w_count_nxt = '0;
            w_step_nxt  = '0;
            w_done_nxt  = (r_state != S_JOG);
        end
`endif
    end

    // NOTE: state is updated only with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_count    <= '0;
            r_steps    <= '0;
            r_half     <= '0;
            r_en       <= '0;
            r_step     <= '0;
            r_dir      <= '0;
            r_done     <= 1'b0;
            r_jog_high <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_count    <= w_count_nxt;
            r_step     <= w_step_nxt;
            r_dir      <= w_dir_nxt;
            r_done     <= w_done_nxt;
            r_jog_high <= w_jog_high_nxt;
            if (w_accept) begin
                r_en    <= cmd_en;
                r_steps <= cmd_steps;
                r_half  <= (cmd_half == '0) ? CNT_W'(1) : cmd_half;
            end
        end
    end

`ifdef AXIS_STEP_SEQUENCER_ENDSTOP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_fault <= 1'b0;
        end else if ((r_state != S_IDLE) && w_es_hit) begin
            r_fault <= 1'b1;
        end
    end
`endif

    assign step = r_step;
    assign dir  = r_dir;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule

// File: doc/axis_step_sequencer.md
AXIS_STEP_SEQUENCER -- requirements
Module: axis_step_sequencer

Interface
REQ-001 Parameter N_AXES, default 3: number of step/dir axis channels.
REQ-002 Parameter CNT_W, default 20: width of the half-period timer and cmd_half.
REQ-003 Parameter STEPS_W, default 16: width of the segment step count.
REQ-004 Parameter DIR_SETUP, default 16: cycles the direction outputs are held stable before the first step edge.
REQ-005 Parameter JOG_HALF, default 40000: half-period in cycles for jog mode.
REQ-006 Port: clk  in  1  system clock, all logic on rising edge.
REQ-007 Port: rst_n  in  1  asynchronous active-low reset.
REQ-008 Port: seq_mode  in  1  1 = segment sequencing, 0 = manual jog.
REQ-009 Port: cmd_valid  in  1  segment command valid.
REQ-010 Port: cmd_ready  out  1  segment command accepted when cmd_valid && cmd_ready.
REQ-011 Port: cmd_en  in  N_AXES  per-axis step enable for the segment.
REQ-012 Port: cmd_dir  in  N_AXES  per-axis direction for the segment.
REQ-013 Port: cmd_steps  in  STEPS_W  step count for the segment.
REQ-014 Port: cmd_half  in  CNT_W  half-period in cycles for the segment.
REQ-015 Port: jog_en / jog_dir  in  N_AXES each  manual jog enable and direction.
REQ-016 Port: step / dir  out  N_AXES each  registered driver outputs.
REQ-017 Port: busy  out  1  high in any state except IDLE.
REQ-018 Port: done  out  1  one-cycle pulse when a segment completes or aborts.

Function
REQ-019 FSM states are IDLE, SETUP, HIGH, LOW and JOG.
REQ-020 cmd_ready = (state == IDLE) && seq_mode; on accept, latch en, dir, steps and half (a half of 0 is latched as 1), drive dir, then go to SETUP.
REQ-021 Accepting a command with cmd_steps == 0 returns to IDLE next cycle with done pulsed and no step edges.
REQ-022 SETUP lasts DIR_SETUP cycles (0 = skip), then go to HIGH.
REQ-023 HIGH lasts exactly half cycles with step = latched en; LOW lasts exactly half cycles with step = 0.
REQ-024 At the end of each LOW, increment the step count: if the count equals steps, pulse done and go to IDLE; otherwise go to HIGH.
REQ-025 Segment pulse period is exactly 2*half cycles and the segment duration is DIR_SETUP + 2*half*steps cycles from accept to done.
REQ-026 dir stays constant from accept until the next accept or jog entry; disabled axes never pulse.
REQ-027 Enter JOG from IDLE when !seq_mode && |jog_en; step[i] = jog_en[i] && high phase, dir = jog_dir, and the period is 2*JOG_HALF.
REQ-028 When jog_en == 0 or seq_mode rises in JOG, step and dir go 0 the next cycle and the FSM returns to IDLE; done is not pulsed.
REQ-029 A seq_mode change during a segment is ignored until the segment ends.
REQ-030 cmd_valid while busy is not accepted and is held by the master.
REQ-031 Timer and step counters saturate-free: compare for equality only, never wrap within a segment.

Reset
REQ-032 On rst_n low, asynchronously: state IDLE, step 0, dir 0, busy 0, done 0, cmd_ready 0, all counters 0.
REQ-033 Reset mid-segment discards the segment with no done pulse; operation resumes from IDLE after release.

Configuration
REQ-034 Macro AXIS_STEP_SEQUENCER_ENDSTOP_EN adds input endstop [N_AXES], active high, and output fault [1].
REQ-035 With the macro defined: endstop passes through a 2-flop synchroniser; a synchronised endstop[i] on an enabled axis with dir[i] == 0 in SETUP, HIGH, LOW or JOG forces step low next cycle, goes to IDLE, pulses done (segment only) and sets fault sticky until the next accept or reset.
REQ-036 Without the macro, the ports do not exist and behaviour is as in REQ-019..REQ-031.

Structure
REQ-037 Package step_seq_pkg holds the state enum type and default constants for CNT_W, STEPS_W and JOG_HALF.
REQ-038 Sub-module sync2 (2-flop synchroniser, parametrised width) is instantiated only under the macro.

Verification
REQ-039 half=4, steps=3, en=3'b101, dir=3'b001, DIR_SETUP=2 -> dir=001 after accept, 3 pulses of 4 high / 4 low on axes 0 and 2 only, done 26 cycles after accept.
REQ-040 cmd_steps=0 -> done next cycle, no step edges; cmd_half=0 -> 1-cycle high / 1-cycle low pulses.
REQ-041 Jog: jog_en=3'b010, JOG_HALF=5 -> axis 1 period 10; drop jog_en mid-high -> step 0 next cycle, busy 0.
REQ-042 cmd_valid held during a segment -> cmd_ready 0 until done, accepted the cycle after done.
REQ-043 rst_n pulsed low mid-HIGH -> step/dir/busy 0 immediately, no done pulse.
REQ-044 With the macro: endstop[0] rises mid-segment with dir[0]=0 -> step 0 within 3 cycles, done pulse, fault=1 until next accept.
